spi_miso_rx_buffer: RTL and testbench
=====================================

Name: spi_miso_rx_buffer

Overview:
- Receive-side counterpart of the MOSI byte buffer in the SSD1331 SPI path.
- Deserializes MISO bits into WIDTH-bit bytes and packs up to N bytes into one wide word.
- Byte k lands in word slot k, so a frame received here matches the slot ordering the transmit buffer consumes.
- Sits between the SPI pin interface (SCK domain) and register or readback logic; gives per-byte and per-frame completion strobes.

Parameters:
- WIDTH, 8: bits per byte.
- N, 8: maximum bytes per frame (1..32).

Ports:
- i_SCK  input  1  clock; all sampling on rising edge.
- i_RST  input  1  reset, asynchronous, active-high.
- i_MISO  input  1  serial data in.
- i_START  input  1  arm a frame; sampled in IDLE, or on the final-bit edge for back-to-back frames.
- i_N_receive  input  5  bytes in the frame; 0 or >N is treated as N.
- o_DATA  output  WIDTH*N  packed frame; byte k in bits [(k+1)*WIDTH-1 : k*WIDTH].
- o_VALID  output  1  one-cycle pulse: o_DATA updated with a complete frame.
- o_BYTE  output  WIDTH  most recently completed byte.
- o_BYTE_VALID  output  1  one-cycle pulse per completed byte.
- o_BYTE_IDX  output  5  slot index of o_BYTE.
- o_BUSY  output  1  high while a frame is in progress.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - o_DATA, o_BYTE and o_BYTE_IDX clear to 0.
  - o_VALID, o_BYTE_VALID and o_BUSY clear to 0.
  - Shift register, bit counter, byte counter and internal frame register clear to 0.
  - A partial frame is discarded; no strobe fires.
- FSM states: IDLE, RECV.
- IDLE:
  - o_VALID and o_BYTE_VALID are 0.
  - On an edge with i_START=1: latch the clamped count, clear the internal frame register and counters, set o_BUSY to 1, go to RECV.
  - i_MISO is not sampled on the start edge.
- RECV, every edge:
  - Shift in i_MISO MSB-first: shift <= {shift[WIDTH-2:0], i_MISO}.
  - bit_cnt increments.
  - o_BYTE_VALID is 0 unless the byte completes on this edge.
- Byte completion (edge where bit_cnt == WIDTH-1):
  - Assembled byte (shift register plus the current bit) is written to internal slot byte_cnt.
  - o_BYTE takes the assembled byte; o_BYTE_IDX takes byte_cnt; o_BYTE_VALID=1 for one cycle.
  - bit_cnt returns to 0; byte_cnt increments.
- Frame completion (byte completion with byte_cnt == count-1):
  - o_DATA takes the full internal frame, including this byte; unused slots (≥ count) are 0.
  - o_VALID=1 for one cycle.
  - If i_START=1 on this edge: latch the new count, clear counters and the internal frame register, stay in RECV with o_BUSY=1. The next edge samples bit 0 of the new frame, with no gap.
  - Otherwise: go to IDLE, o_BUSY=0.
- Latency and hold:
  - With the start edge as edge 0, data bits are sampled on edges 1..WIDTH*count.
  - o_VALID is high in the cycle after edge WIDTH*count.
  - o_DATA holds its value until the next frame completes.
- i_START in RECV on any other edge is ignored.
- i_N_receive changing mid-frame has no effect (the count is latched).
- Simultaneous o_BYTE_VALID and o_VALID on the last byte is the required behaviour.

Optional Feature:
- Macro: MISO_LSB_FIRST_EN.
- Defined: bytes are received LSB-first; shift <= {i_MISO, shift[WIDTH-1:1]}. Completion timing, strobes and slot packing are unchanged.
- Undefined: MSB-first as specified above.

Test Plan (WIDTH=8, N=4):
- Reset: assert i_RST asynchronously mid-cycle -> all outputs 0 immediately, o_BUSY=0.
- Full frame: i_START with i_N_receive=4, bytes 0xA5, 0x3C, 0x0F, 0xF0 MSB-first -> o_BYTE_VALID after edges 8/16/24/32 with o_BYTE_IDX 0..3; o_VALID one cycle after edge 32; o_DATA=32'hF00F3CA5; o_BUSY=0 after.
- Partial and clamp:
  - i_N_receive=2 with bytes 0x12, 0x34 -> o_DATA=32'h00003412, o_VALID after edge 16.
  - i_N_receive=0 -> 4 bytes received.
  - i_N_receive=9 -> 4 bytes received.
- Back-to-back: i_START=1 at edge 32 with a second frame 0x01, 0x02, 0x03, 0x04 -> o_BUSY stays 1, second o_VALID after edge 64, o_DATA=32'h04030201.
- Abort and ignore:
  - i_START pulsed at edge 5 is ignored.
  - i_RST at edge 12 -> no o_VALID; a fresh frame afterwards decodes correctly.
- Macro MISO_LSB_FIRST_EN defined: wire bits 1,0,1,0,0,1,0,1 (first to last) -> o_BYTE=8'hA5.

Source files
------------

// File: rtl/spi_miso_rx_buffer.sv
// spi_miso_rx_buffer: deserializes MISO into WIDTH-bit bytes packed into an N-byte frame word.
// Define MISO_LSB_FIRST_EN to receive bytes LSB-first; MSB-first otherwise.
module spi_miso_rx_buffer #(
   parameter int WIDTH = 8,
   parameter int N     = 8
) (
   input  logic               i_SCK,
   input  logic               i_RST,
   input  logic               i_MISO,
   input  logic               i_START,
   input  logic [4:0]         i_N_receive,
   output logic [WIDTH*N-1:0] o_DATA,
   output logic               o_VALID,
   output logic [WIDTH-1:0]   o_BYTE,
   output logic               o_BYTE_VALID,
   output logic [4:0]         o_BYTE_IDX,
   output logic               o_BUSY
);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic {IDLE, RECV} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] shift, asm_byte;
   logic [BW-1:0] bit_cnt;
   logic [4:0] byte_cnt;
   logic [5:0] count, count_in;
   logic [WIDTH*N-1:0] frame, frame_w;
   logic byte_done, frame_done;
   always_comb begin
      count_in = (i_N_receive == 5'd0 || {1'b0, i_N_receive} > 6'(N)) ? 6'(N) : {1'b0, i_N_receive};
`ifdef MISO_LSB_FIRST_EN
      asm_byte = {i_MISO, shift[WIDTH-1:1]};
`else
      asm_byte = {shift[WIDTH-2:0], i_MISO};
`endif
      byte_done = state == RECV && bit_cnt == BW'(WIDTH-1);
      frame_done = byte_done && {1'b0, byte_cnt} == count - 6'd1;
      frame_w = frame;
      for (int k = 0; k < N; k++)
         if (byte_cnt == 5'(k)) frame_w[k*WIDTH +: WIDTH] = asm_byte;
      state_nxt = state;
      if (state == IDLE) state_nxt = i_START ? RECV : IDLE;
      else if (frame_done && !i_START) state_nxt = IDLE;
   end
   always_ff @(posedge i_SCK or posedge i_RST) begin
      if (i_RST) begin
         state        <= IDLE;
         shift        <= '0;
         bit_cnt      <= '0;
         byte_cnt     <= '0;
         count        <= '0;
         frame        <= '0;
         o_DATA       <= '0;
         o_BYTE       <= '0;
         o_BYTE_IDX   <= '0;
         o_VALID      <= 1'b0;
         o_BYTE_VALID <= 1'b0;
         o_BUSY       <= 1'b0;
      end else begin
         state        <= state_nxt;
         o_VALID      <= 1'b0;
         o_BYTE_VALID <= 1'b0;
         if (state == IDLE) begin
            if (i_START) begin
               count    <= count_in;
               frame    <= '0;
               bit_cnt  <= '0;
               byte_cnt <= '0;
               o_BUSY   <= 1'b1;
            end
         end else begin
            shift   <= asm_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (byte_done) begin
               frame        <= frame_w;
               o_BYTE       <= asm_byte;
               o_BYTE_IDX   <= byte_cnt;
               o_BYTE_VALID <= 1'b1;
               bit_cnt      <= '0;
               byte_cnt     <= byte_cnt + 5'd1;
               if (frame_done) begin
                  o_DATA  <= frame_w;
                  o_VALID <= 1'b1;
                  // a start on the final edge chains straight into the next frame
                  if (i_START) begin
                     count    <= count_in;
                     frame    <= '0;
                     byte_cnt <= '0;
                  end else o_BUSY <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_miso_rx_buffer.sv
// tb_spi_miso_rx_buffer: randomized frame checks of spi_miso_rx_buffer against a byte-level model.
module tb_spi_miso_rx_buffer;
   localparam int W  = 8;
   localparam int NB = 4;
   logic          i_SCK = 1'b0;
   logic          i_RST = 1'b1;
   logic          i_MISO = 1'b0;
   logic          i_START = 1'b0;
   logic [4:0]    i_N_receive = 5'd0;
   logic [W*NB-1:0] o_DATA;
   logic          o_VALID;
   logic [W-1:0]  o_BYTE;
   logic          o_BYTE_VALID;
   logic [4:0]    o_BYTE_IDX;
   logic          o_BUSY;
   int tests = 0;
   int fails = 0;

   spi_miso_rx_buffer #(.WIDTH(W), .N(NB)) dut (
      .i_SCK(i_SCK), .i_RST(i_RST), .i_MISO(i_MISO), .i_START(i_START),
      .i_N_receive(i_N_receive), .o_DATA(o_DATA), .o_VALID(o_VALID),
      .o_BYTE(o_BYTE), .o_BYTE_VALID(o_BYTE_VALID), .o_BYTE_IDX(o_BYTE_IDX),
      .o_BUSY(o_BUSY)
   );

   always #5 i_SCK = ~i_SCK;

   task automatic tick;
      @(posedge i_SCK);
      #1;
   endtask

   task automatic run_frame(input int nreq, input logic [31:0] bytes, input bit do_start,
                            input bit chain, input int chain_n, input bit noise);
      int cnt;
      logic [31:0] exp_data;
      logic [7:0] b;
      bit last;
      cnt = (nreq == 0 || nreq > NB) ? NB : nreq;
      exp_data = '0;
      for (int k = 0; k < cnt; k++) exp_data[8*k +: 8] = bytes[8*k +: 8];
      if (do_start) begin
         i_START = 1'b1;
         i_N_receive = 5'(nreq);
         tick();
         i_START = 1'b0;
         tests++;
         if (o_BUSY !== 1'b1 || o_VALID !== 1'b0 || o_BYTE_VALID !== 1'b0) begin
            fails++;
            $display("FAIL start_edge: busy=%b valid=%b byte_valid=%b, expected 1 0 0", o_BUSY, o_VALID, o_BYTE_VALID);
         end
      end
      for (int k = 0; k < cnt; k++) begin
         b = bytes[8*k +: 8];
         for (int j = 0; j < 8; j++) begin
            last = (k == cnt - 1) && (j == 7);
`ifdef MISO_LSB_FIRST_EN
            i_MISO = b[j];
`else
            i_MISO = b[7-j];
`endif
            i_START = last ? chain : (noise ? 1'($urandom) : 1'b0);
            if (noise) i_N_receive = 5'($urandom);
            if (last && chain) i_N_receive = 5'(chain_n);
            tick();
            tests++;
            if (o_BYTE_VALID !== (j == 7)) begin
               fails++;
               $display("FAIL byte_valid byte %0d bit %0d: got %b expected %b", k, j, o_BYTE_VALID, j == 7);
            end
            if (j == 7) begin
               tests++;
               if (o_BYTE !== b || o_BYTE_IDX !== 5'(k)) begin
                  fails++;
                  $display("FAIL byte_data: got %h idx %0d expected %h idx %0d", o_BYTE, o_BYTE_IDX, b, k);
               end
            end
            tests++;
            if (o_VALID !== last) begin
               fails++;
               $display("FAIL frame_valid byte %0d bit %0d: got %b expected %b", k, j, o_VALID, last);
            end
            tests++;
            if (o_BUSY !== (last ? chain : 1'b1)) begin
               fails++;
               $display("FAIL busy byte %0d bit %0d: got %b expected %b", k, j, o_BUSY, last ? chain : 1'b1);
            end
            if (last) begin
               tests++;
               if (o_DATA !== exp_data) begin
                  fails++;
                  $display("FAIL frame_data: got %h expected %h", o_DATA, exp_data);
               end
            end
         end
      end
      i_START = 1'b0;
   endtask

   task automatic test_reset;
      tick();
      tick();
      tests++;
      if ({o_DATA, o_BYTE, o_BYTE_IDX, o_VALID, o_BYTE_VALID, o_BUSY} !== '0) begin
         fails++;
         $display("FAIL reset_state: got %h expected 0", {o_DATA, o_BYTE, o_BYTE_IDX, o_VALID, o_BYTE_VALID, o_BUSY});
      end
      i_RST = 1'b0;
   endtask

   task automatic test_full_frame;
      run_frame(4, 32'hF00F3CA5, 1'b1, 1'b0, 0, 1'b0);
      tick();
      tests++;
      if (o_VALID !== 1'b0 || o_BUSY !== 1'b0 || o_DATA !== 32'hF00F3CA5) begin
         fails++;
         $display("FAIL idle_hold: valid=%b busy=%b data=%h expected 0 0 f00f3ca5", o_VALID, o_BUSY, o_DATA);
      end
   endtask

   task automatic test_partial_clamp;
      run_frame(2, 32'hDEAD3412, 1'b1, 1'b0, 0, 1'b0);
      run_frame(0, $urandom, 1'b1, 1'b0, 0, 1'b0);
      run_frame(9, $urandom, 1'b1, 1'b0, 0, 1'b0);
      for (int i = 0; i < 6; i++) run_frame($urandom_range(1, 31), $urandom, 1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_back_to_back;
      int n1, n2, n3;
      run_frame(4, $urandom, 1'b1, 1'b1, 4, 1'b0);
      run_frame(4, 32'h04030201, 1'b0, 1'b0, 0, 1'b0);
      n1 = $urandom_range(0, 9);
      n2 = $urandom_range(0, 9);
      n3 = $urandom_range(0, 9);
      run_frame(n1, $urandom, 1'b1, 1'b1, n2, 1'b0);
      run_frame(n2, $urandom, 1'b0, 1'b1, n3, 1'b0);
      run_frame(n3, $urandom, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_ignore;
      for (int i = 0; i < 3; i++) run_frame($urandom_range(0, 9), $urandom, 1'b1, 1'b0, 0, 1'b1);
   endtask

   task automatic test_abort;
      i_START = 1'b1;
      i_N_receive = 5'd4;
      tick();
      i_START = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         i_MISO = 1'($urandom);
         tick();
         tests++;
         if (o_VALID !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_valid edge %0d: got %b expected 0", e, o_VALID);
         end
      end
      #2 i_RST = 1'b1;
      #1;
      tests++;
      if ({o_DATA, o_BYTE, o_BYTE_IDX, o_VALID, o_BYTE_VALID, o_BUSY} !== '0) begin
         fails++;
         $display("FAIL async_reset: got %h expected 0", {o_DATA, o_BYTE, o_BYTE_IDX, o_VALID, o_BYTE_VALID, o_BUSY});
      end
      #1 i_RST = 1'b0;
      tick();
      tests++;
      if (o_BUSY !== 1'b0 || o_VALID !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_idle: busy=%b valid=%b expected 0 0", o_BUSY, o_VALID);
      end
      run_frame(4, $urandom, 1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_lsb_pattern;
      run_frame(1, 32'h000000A5, 1'b1, 1'b0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_partial_clamp();
      test_back_to_back();
      test_ignore();
      test_abort();
      test_lsb_pattern();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
